// File: rtl/debounce_pkg.sv
// Shared types and default constants for the debounce / edge-detect front end.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } deb_state_e;

  localparam int unsigned SYNC_STAGES_DEF   = 2;
  localparam int unsigned STABLE_CYCLES_DEF = 4;

endpackage

// File: rtl/sync_chain.sv
// N-stage single-bit synchroniser with async active-low reset to a configurable value.
module sync_chain #(
  parameter int unsigned N       = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] stages;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stages <= {N{RST_VAL}};
    else      stages <= {stages[N-2:0], d};
  end

  assign q = stages[N-1];

endmodule

// File: rtl/debounce_edge_det.sv
// Synchronise, debounce and edge-detect a raw asynchronous input.
// Optional DEBOUNCE_EDGE_COUNT_EN adds an 8-bit wrapping count of accepted rises (edge_cnt).
module debounce_edge_det
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic       busy
`ifdef DEBOUNCE_EDGE_COUNT_EN
  ,
  output logic [7:0] edge_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam deb_state_e RST_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  logic             s;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d, rise_d, fall_d, busy_d;

  sync_chain #(
    .N       (SYNC_STAGES),
    .RST_VAL (RESET_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      level   <= RESET_LEVEL;
      rise    <= 1'b0;
      fall    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= level_d;
      rise    <= rise_d;
      fall    <= fall_d;
      busy    <= busy_d;
    end
  end

  // Qualification FSM: a change is accepted only after STABLE_CYCLES consecutive samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RST_STATE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
  end

`ifdef DEBOUNCE_EDGE_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        edge_cnt <= 8'd0;
    else if (rise_d) edge_cnt <= edge_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_debounce_edge_det.sv
// Scoreboard bench for debounce_edge_det: stimulus queues expected pulses, a monitor checks them.
module tb_debounce_edge_det;

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic level, rise, fall, busy;
`ifdef DEBOUNCE_EDGE_COUNT_EN
  logic [7:0] edge_cnt;
`endif
  logic dffb_q;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int cyc;
    bit is_rise;
  } ev_t;
  ev_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  debounce_edge_det dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .level    (level),
    .rise     (rise),
    .fall     (fall),
    .busy     (busy)
`ifdef DEBOUNCE_EDGE_COUNT_EN
    ,
    .edge_cnt (edge_cnt)
`endif
  );

  // Downstream dffb stage fed by the debounced level
  always @(posedge clk or negedge rst) begin
    if (!rst) dffb_q <= 1'b0;
    else      dffb_q <= level;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input int at, input bit is_rise);
    ev_t e;
    e.cyc = at;
    e.is_rise = is_rise;
    exp_q.push_back(e);
  endtask

  // Monitor: every observed pulse must match the head of the expectation queue
  always @(negedge clk) begin
    if (rise || fall) begin
      ev_t e;
      check("rise_fall_exclusive", 32'(rise && fall), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(rise ? 2 : 1), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("pulse_kind_rise", 32'(rise), 32'(e.is_rise));
        check("pulse_level", 32'(level), 32'(e.is_rise));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b0;
    din = 1'b1;

    // Reset hold with din high
    tick(1);
    for (int i = 0; i < 3; i++) begin
      check("rst_level", 32'(level), 32'd0);
      check("rst_rise", 32'(rise), 32'd0);
      check("rst_fall", 32'(fall), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      tick(1);
    end
`ifdef DEBOUNCE_EDGE_COUNT_EN
    check("rst_edge_cnt", 32'(edge_cnt), 32'd0);
`endif

    // Release: first rise on the 6th edge, downstream flop one edge later
    rst = 1'b1;
    k = cyc;
    expect_pulse(k + 6, 1'b1);
    tick(5);
    check("lat_edge5_level", 32'(level), 32'd0);
    tick(1);
    check("lat_edge6_level", 32'(level), 32'd1);
    check("lat_edge6_dffb", 32'(dffb_q), 32'd0);
    tick(1);
    check("lat_edge7_dffb", 32'(dffb_q), 32'd1);
    tick(3);

    // Clean fall
    din = 1'b0;
    k = cyc;
    expect_pulse(k + 6, 1'b0);
    tick(10);
    check("fall_level", 32'(level), 32'd0);

    // Glitch: three post-sync cycles high is not enough
    din = 1'b1;
    k = cyc;
    tick(3);
    din = 1'b0;
    tick(1);
    check("glitch_busy", 32'(busy), 32'd1);
    check("glitch_level_mid", 32'(level), 32'd0);
    tick(8);
    check("glitch_busy_end", 32'(busy), 32'd0);
    check("glitch_level_end", 32'(level), 32'd0);

    // Clean toggle: high for 10 cycles then low
    din = 1'b1;
    k = cyc;
    expect_pulse(k + 6, 1'b1);
    tick(10);
    check("toggle_level_hi", 32'(level), 32'd1);
    din = 1'b0;
    expect_pulse(k + 16, 1'b0);
    tick(10);
    check("toggle_level_lo", 32'(level), 32'd0);

    // Reset mid-qualification, asynchronously between edges
    din = 1'b1;
    tick(4);
    check("midq_busy_before", 32'(busy), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    check("midq_busy_async", 32'(busy), 32'd0);
    check("midq_level_async", 32'(level), 32'd0);
    tick(2);
    rst = 1'b1;
    k = cyc;
    expect_pulse(k + 6, 1'b1);
    tick(2);
    check("midq_requal_busy", 32'(busy), 32'd0);
    tick(1);
    check("midq_requal_busy3", 32'(busy), 32'd1);
    tick(4);
    check("midq_requal_level", 32'(level), 32'd1);
    tick(2);

`ifdef DEBOUNCE_EDGE_COUNT_EN
    // One rise since last reset; 256 more wraps the counter back to 1
    check("cnt_after_one", 32'(edge_cnt), 32'd1);
    for (int i = 0; i < 256; i++) begin
      din = 1'b0;
      k = cyc;
      expect_pulse(k + 6, 1'b0);
      tick(8);
      din = 1'b1;
      k = cyc;
      expect_pulse(k + 6, 1'b1);
      tick(8);
      if (i == 254) check("cnt_wrap_zero", 32'(edge_cnt), 32'd0);
    end
    check("cnt_wrap_one", 32'(edge_cnt), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("cnt_reset", 32'(edge_cnt), 32'd0);
    check("cnt_reset_level", 32'(level), 32'd0);
    tick(2);
    din = 1'b0;
    rst = 1'b1;
`endif

    tick(10);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
